// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchronizer, counter-qualified RELEASED/PRESSED FSM, press/release pulses.
// Optional hold detector (long_press) built only when BUTTON_LONG_PRESS_EN is defined.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk_12mhz,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             PAD_RELEASED = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be 2 or more");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  typedef enum logic {ST_RELEASED, ST_PRESSED} state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_press_pulse;
  logic             r_release_pulse;

  logic w_sync_pressed;
  logic w_disagree;
  logic w_flip;

  // Reset loads the released pad level so leaving reset never looks like an edge
  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      r_sync1 <= PAD_RELEASED;
      r_sync2 <= PAD_RELEASED;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_pressed = r_sync2 ^ PAD_RELEASED;
  assign w_disagree     = w_sync_pressed != (r_state == ST_PRESSED);
  assign w_flip         = w_disagree && (r_db_cnt == DB_LAST);

  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      r_state         <= ST_RELEASED;
      r_db_cnt        <= '0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      if (!w_disagree) begin
        r_db_cnt <= '0;
      end else if (w_flip) begin
        r_db_cnt <= '0;
        case (r_state)
          ST_RELEASED: begin
            r_state       <= ST_PRESSED;
            r_press_pulse <= 1'b1;
          end
          default: begin
            r_state         <= ST_RELEASED;
            r_release_pulse <= 1'b1;
          end
        endcase
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign btn_level     = (r_state == ST_PRESSED);
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_press;

  // Clearing on w_flip drops long_press in the same cycle release_pulse rises
  always_ff @(posedge clk_12mhz) begin
    if (rst || (r_state != ST_PRESSED) || w_flip) begin
      r_hold_cnt   <= '0;
      r_long_press <= 1'b0;
    end else begin
      if (r_hold_cnt == HOLD_LAST) r_long_press <= 1'b1;
      if (r_hold_cnt != HOLD_MAX)  r_hold_cnt   <= r_hold_cnt + 1'b1;
    end
  end

  assign long_press = r_long_press;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
// Long-press expectations follow BUTTON_LONG_PRESS_EN the same way the design does.
module tb_button_debounce;

`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk_12mhz = 1'b0;
  logic rst       = 1'b1;
  logic btn_in    = 1'b1;
  logic btn_level, press_pulse, release_pulse, long_press;

  int pass_cnt = 0;
  int total    = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk_12mhz    (clk_12mhz),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_12mhz);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic lvl, input logic pp,
                         input logic rp, input logic lp);
    chk({tag, ".level"},   btn_level,     lvl);
    chk({tag, ".press"},   press_pulse,   pp);
    chk({tag, ".release"}, release_pulse, rp);
    chk({tag, ".long"},    long_press,    lp);
  endtask

  initial begin
    // Reset with the pad released, then 50 idle cycles
    rst    = 1'b1;
    btn_in = 1'b1;
    tick(5);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Clean press: new level and pulse on the 6th sampling edge
    btn_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_out("press_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1);
    chk_out("press_edge6", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("press_edge7", 1'b1, 1'b0, 1'b0, 1'b0);

    // Clean release from pressed; long_press may be set by now only if the hold reached 20
    btn_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_out("release_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick(1);
    chk_out("release_edge6", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_out("release_edge7", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(10);

    // Bounce 0x2, 1x1, 0x3, 1x2 then steady 0: a single press 6 edges later
    btn_in = 1'b0; tick(2); chk("bounce_a.level", btn_level, 1'b0);
    btn_in = 1'b1; tick(1); chk("bounce_b.press", press_pulse, 1'b0);
    btn_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bounce_c.press", press_pulse, 1'b0);
    end
    btn_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("bounce_d.press", press_pulse, 1'b0);
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_out("bounce_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1);
    chk_out("bounce_press", 1'b1, 1'b1, 1'b0, 1'b0);

    // Hold: long_press 20 edges after the press pulse, then stays high
    tick(19);
    chk_out("hold19", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("hold20", 1'b1, 1'b0, 1'b0, LP_EN);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk_out("hold_keep", 1'b1, 1'b0, 1'b0, LP_EN);
    end

    // Release after long hold: long_press drops together with release_pulse
    btn_in = 1'b1;
    tick(5);
    chk_out("long_rel5", 1'b1, 1'b0, 1'b0, LP_EN);
    tick(1);
    chk_out("long_rel6", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk_out("long_rel7", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(10);

    // Reset two edges into a debounce while held: press requalified after reset
    btn_in = 1'b0;
    tick(2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_out("rst_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1);
    chk_out("rst_press6", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("rst_press7", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
